// File: rtl/exu_mc.sv
// exu_mc: multi-cycle execution unit (ALU ops, iterative shift-add MUL, restoring DIVU/REMU).
// Latency: ALU/illegal ops 1 cycle from accept; MUL/DIVU/REMU DATAWIDTH+1 cycles from accept.
// Backpressure: in_ready only in IDLE; out_ready=0 holds DONE with result/err frozen.
//
// Ports: clk/rst (async, active-high); in_valid/in_ready request handshake with
// src1, src2, imm, src_sel (0: b=src2, 1: b=imm) and op; out_valid/out_ready
// response handshake with registered result and err (1 = illegal op).
// Optional feature macro: EXU_MC_DIV_EN builds the divider (ops 11/12); without it
// those ops are reported as illegal in a single cycle.
module exu_mc #(
  parameter int DATAWIDTH = 32,
  parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] src1,
  input  logic [DATAWIDTH-1:0] src2,
  input  logic [DATAWIDTH-1:0] imm,
  input  logic                 src_sel,
  input  logic [3:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] result,
  output logic                 err
);
  localparam int SHW = $clog2(DATAWIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10,
                         OP_DIVU = 4'd11, OP_REMU = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [DATAWIDTH-1:0] b;
  logic [SHW-1:0]       shamt;
  logic                 accept, illegal, is_iter;
  logic [DATAWIDTH-1:0] alu;

  // Iterative datapath. MUL: acc = partial product, md = shifted multiplicand,
  // mq = multiplier consumed LSB first. DIV: acc = partial remainder,
  // mq = dividend shifting out / quotient shifting in, md = divisor.
  logic [3:0]           op_q;
  logic [DATAWIDTH-1:0] acc, mq, md;
  logic [CNTW-1:0]      cnt;
  logic [DATAWIDTH-1:0] acc_mul;

  assign b         = src_sel ? imm : src2;
  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign acc_mul   = mq[0] ? (acc + md) : acc;

`ifdef EXU_MC_DIV_EN
  logic [DATAWIDTH:0]   rem_sh, rem_sub;
  logic                 ge;
  logic [DATAWIDTH-1:0] rem_nxt, quo_nxt;

  // Restoring step; a zero divisor always "fits", giving all-ones quotient
  // and the dividend as remainder without any special casing.
  assign rem_sh  = {acc, mq[DATAWIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, md});
  assign rem_sub = rem_sh - {1'b0, md};
  assign rem_nxt = ge ? rem_sub[DATAWIDTH-1:0] : rem_sh[DATAWIDTH-1:0];
  assign quo_nxt = {mq[DATAWIDTH-2:0], ge};
  assign is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign illegal = (op > OP_REMU);
`else
  assign is_iter = (op == OP_MUL);
  assign illegal = (op > OP_MUL);
`endif

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = src1 + b;
      OP_SUB:  alu = src1 - b;
      OP_AND:  alu = src1 & b;
      OP_OR:   alu = src1 | b;
      OP_XOR:  alu = src1 ^ b;
      OP_SLL:  alu = src1 << shamt;
      OP_SRL:  alu = src1 >> shamt;
      OP_SRA:  alu = $unsigned($signed(src1) >>> shamt);
      OP_SLT:  alu = {{(DATAWIDTH-1){1'b0}}, ($signed(src1) < $signed(b))};
      OP_SLTU: alu = {{(DATAWIDTH-1){1'b0}}, (src1 < b)};
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_iter ? BUSY : DONE;
      BUSY:    if (cnt == CNTW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      acc    <= '0;
      mq     <= '0;
      md     <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op;
          if (is_iter) begin
            acc <= '0;
            cnt <= CNTW'(DATAWIDTH);
            mq  <= (op == OP_MUL) ? b    : src1;
            md  <= (op == OP_MUL) ? src1 : b;
          end else begin
            result <= illegal ? '0 : alu;
            err    <= illegal;
          end
        end
        BUSY: begin
          cnt <= cnt - CNTW'(1);
`ifdef EXU_MC_DIV_EN
          if (op_q != OP_MUL) begin
            acc <= rem_nxt;
            mq  <= quo_nxt;
          end else
`endif
          begin
            acc <= acc_mul;
            md  <= md << 1;
            mq  <= mq >> 1;
          end
          if (cnt == CNTW'(1)) begin
            err <= 1'b0;
`ifdef EXU_MC_DIV_EN
            if (op_q == OP_DIVU)      result <= quo_nxt;
            else if (op_q == OP_REMU) result <= rem_nxt;
            else
`endif
            result <= acc_mul;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_mc.sv
module tb_exu_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, src_sel, out_valid, out_ready, err;
  logic [31:0] src1, src2, imm, result;
  logic [3:0]  op;

  int checks   = 0;
  int failures = 0;

`ifdef EXU_MC_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  exu_mc #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .imm(imm), .src_sel(src_sel), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic        sel;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge with
  // inputs scrambled to show they are not sampled later.
  task automatic accept_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] bb,
                            input logic [31:0] im, input logic s);
    in_valid = 1'b1; op = o; src1 = a; src2 = bb; imm = im; src_sel = s;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); src1 = $urandom; src2 = $urandom;
    imm = $urandom; src_sel = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
    accept_req(v.op, v.a, v.b, v.im, v.sel);
    wait_valid(lat);
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " result"}, result, v.res);
    chk({v.name, " err"}, 32'(err), 32'(v.err));
    @(posedge clk); #1;
    chk({v.name, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; src1 = '0; src2 = '0; imm = '0;
    src_sel = 1'b0; op = '0;

    vecs.push_back('{"add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,  1'b0, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{"sub_imm",  4'd1,  32'h3,         32'h77,        32'h5,  1'b1, 32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{"and",      4'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0,  1'b0, 32'h00F0_1234, 1'b0, 1});
    vecs.push_back('{"or_imm",   4'd3,  32'hF000_0000, 32'h0,         32'hF,  1'b1, 32'hF000_000F, 1'b0, 1});
    vecs.push_back('{"xor",      4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,  1'b0, 32'hF0F0_0F0F, 1'b0, 1});
    vecs.push_back('{"sll_mask", 4'd5,  32'h1,         32'h21,        32'h0,  1'b0, 32'h0000_0002, 1'b0, 1});
    vecs.push_back('{"srl31",    4'd6,  32'h8000_0000, 32'h1F,        32'h0,  1'b0, 32'h0000_0001, 1'b0, 1});
    vecs.push_back('{"sra",      4'd7,  32'h8000_0000, 32'h24,        32'h0,  1'b0, 32'hF800_0000, 1'b0, 1});
    vecs.push_back('{"slt",      4'd8,  32'hFFFF_FFFF, 32'h1,         32'h0,  1'b0, 32'h1,         1'b0, 1});
    vecs.push_back('{"sltu",     4'd9,  32'hFFFF_FFFF, 32'h1,         32'h0,  1'b0, 32'h0,         1'b0, 1});
    vecs.push_back('{"sltu_rev", 4'd9,  32'h1,         32'hFFFF_FFFF, 32'h0,  1'b0, 32'h1,         1'b0, 1});
    vecs.push_back('{"mul",      4'd10, 32'h0001_0003, 32'h0002_0005, 32'h0,  1'b0, 32'h000B_000F, 1'b0, 33});
    vecs.push_back('{"mul_m1",   4'd10, 32'hFFFF_FFFF, 32'h0,  32'hFFFF_FFFF, 1'b1, 32'h1,         1'b0, 33});
    vecs.push_back('{"mul_zero", 4'd10, 32'h1234_5678, 32'h0,         32'h0,  1'b0, 32'h0,         1'b0, 33});
    vecs.push_back('{"divu",     4'd11, 32'd100,       32'd7,         32'h0,  1'b0, DIV ? 32'd14 : 32'd0,        !DIV, DIV ? 33 : 1});
    vecs.push_back('{"remu",     4'd12, 32'd100,       32'd7,         32'h0,  1'b0, DIV ? 32'd2 : 32'd0,         !DIV, DIV ? 33 : 1});
    vecs.push_back('{"divu_z",   4'd11, 32'd5,         32'd0,         32'h0,  1'b0, DIV ? 32'hFFFF_FFFF : 32'd0, !DIV, DIV ? 33 : 1});
    vecs.push_back('{"remu_z",   4'd12, 32'd5,         32'd0,         32'h0,  1'b0, DIV ? 32'd5 : 32'd0,         !DIV, DIV ? 33 : 1});
    vecs.push_back('{"divu_big", 4'd11, 32'hFFFF_FFFF, 32'd0,         32'd1,  1'b1, DIV ? 32'hFFFF_FFFF : 32'd0, !DIV, DIV ? 33 : 1});
    vecs.push_back('{"op13",     4'd13, 32'h5,         32'h5,         32'h0,  1'b0, 32'h0,         1'b1, 1});
    vecs.push_back('{"op15",     4'd15, 32'h5,         32'h5,         32'h0,  1'b0, 32'h0,         1'b1, 1});
    vecs.push_back('{"add_after_ill", 4'd0, 32'd40,    32'd2,         32'h0,  1'b0, 32'd42,        1'b0, 1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset err", 32'(err), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // MUL with in_valid held during BUSY: must be ignored, in_ready low throughout.
    accept_req(4'd10, 32'h0001_0003, 32'h0002_0005, 32'h0, 1'b0);
    in_valid = 1'b1; op = 4'd0; src1 = 32'd1; src2 = 32'd1; src_sel = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk("busy in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("busy mul latency", 32'(lat), 32'd33);
    chk("busy mul result", result, 32'h000B_000F);
    @(posedge clk); #1;
    chk("busy mul idle", 32'(in_ready), 32'd1);
    chk("busy mul no extra", 32'(out_valid), 32'd0);

    // Backpressure on illegal op, then on a non-zero ALU result.
    for (int k = 0; k < 2; k++) begin
      logic [31:0] er;
      logic        ee;
      er = (k == 0) ? 32'h0 : 32'hFFFF_FFFE;
      ee = (k == 0);
      out_ready = 1'b0;
      if (k == 0) accept_req(4'd14, 32'h9, 32'h9, 32'h0, 1'b0);
      else        accept_req(4'd1, 32'h3, 32'h0, 32'h5, 1'b1);
      wait_valid(lat);
      chk("bp latency", 32'(lat), 32'd1);
      repeat (10) begin
        @(posedge clk); #1;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp result", result, er);
        chk("bp err", 32'(err), 32'(ee));
        chk("bp in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release out_valid", 32'(out_valid), 32'd0);
      chk("bp release in_ready", 32'(in_ready), 32'd1);
    end

    // Async reset in the middle of a MUL.
    accept_req(4'd10, 32'h0001_0003, 32'h0002_0005, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst mid out_valid", 32'(out_valid), 32'd0);
    chk("rst mid in_ready", 32'(in_ready), 32'd1);
    chk("rst mid result", result, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    run_vec('{"post_rst_add", 4'd0, 32'd2, 32'd2, 32'h0, 1'b0, 32'd4, 1'b0, 1});
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no stale mul", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
